// File: rtl/cpu_pkg.sv
// Shared types for the execute stage:
// ALU/mul-div opcodes, forward selects, FSM states.
package cpu_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int MD_ITERS   = 32;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLT   = 4'd5,
    ALU_SLTU  = 4'd6,
    ALU_SLL   = 4'd7,
    ALU_SRL   = 4'd8,
    ALU_SRA   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    FWD_RD = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

endpackage

// File: rtl/execute_muldiv_unit.sv
// Iterative RV32M unit: shift-add multiply and
// restoring divide on magnitudes, sign fix at the end.
module muldiv_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        flush_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);

  md_state_e  state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  muldiv_op_e op_q;
  logic [31:0] hi_q, lo_q, mc_q, a_q;
  logic        neg_q, aneg_q, bz_q, ovf_q;

  logic        a_sgn, b_sgn, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] msum, dsh, ddiff;
  logic        dge;
  logic [63:0] prod, prod_s;
  logic [31:0] q_s, r_s;
  logic        go;

  // Operand signedness and magnitudes at start
  always_comb begin
    a_sgn = (op_i != MD_MULHU) && (op_i != MD_DIVU)
         && (op_i != MD_REMU);
    b_sgn = a_sgn && (op_i != MD_MULHSU);
    a_neg = a_sgn && a_i[31];
    b_neg = b_sgn && b_i[31];
    a_mag = a_neg ? (32'd0 - a_i) : a_i;
    b_mag = b_neg ? (32'd0 - b_i) : b_i;
  end

  // One radix-2 step for multiply and divide
  always_comb begin
    msum  = {1'b0, hi_q}
          + (lo_q[0] ? {1'b0, mc_q} : 33'd0);
    dsh   = {hi_q, lo_q[31]};
    ddiff = dsh - {1'b0, mc_q};
    dge   = dsh >= {1'b0, mc_q};
  end

  // FSM next state, busy and done
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    go      = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        if (start_i && !flush_i) begin
          go      = 1'b1;
          busy_o  = 1'b1;
          cnt_d   = 5'(MD_ITERS - 1);
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        busy_o = !flush_i;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd0) state_d = MD_DONE;
      end
      MD_DONE: begin
        done_o  = !flush_i;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
    if (flush_i) state_d = MD_IDLE;
    if (!rst_n)  busy_o  = 1'b0;
  end

  // State, counter and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      mc_q    <= '0;
      a_q     <= '0;
      neg_q   <= 1'b0;
      aneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (go) begin
        op_q   <= muldiv_op_e'(op_i);
        hi_q   <= '0;
        lo_q   <= a_mag;
        mc_q   <= b_mag;
        a_q    <= a_i;
        neg_q  <= a_neg ^ b_neg;
        aneg_q <= a_neg;
        bz_q   <= (b_i == 32'd0);
        ovf_q  <= a_sgn && (a_i == 32'h8000_0000)
               && (b_i == 32'hFFFF_FFFF);
      end else if (state_q == MD_RUN) begin
        if (op_q[2]) begin
          hi_q <= dge ? ddiff[31:0] : dsh[31:0];
          lo_q <= {lo_q[30:0], dge};
        end else begin
          hi_q <= msum[32:1];
          lo_q <= {msum[0], lo_q[31:1]};
        end
      end
    end
  end

  // Sign fix-up and special cases
  always_comb begin
    prod   = {hi_q, lo_q};
    prod_s = neg_q ? (64'd0 - prod) : prod;
    q_s    = neg_q ? (32'd0 - lo_q) : lo_q;
    r_s    = aneg_q ? (32'd0 - hi_q) : hi_q;
    result_o = '0;
    unique case (op_q)
      MD_MUL:   result_o = prod_s[31:0];
      MD_MULH,
      MD_MULHSU,
      MD_MULHU: result_o = prod_s[63:32];
      MD_DIV,
      MD_DIVU: begin
        if (bz_q)       result_o = 32'hFFFF_FFFF;
        else if (ovf_q) result_o = 32'h8000_0000;
        else            result_o = q_s;
      end
      MD_REM,
      MD_REMU: begin
        if (bz_q)       result_o = a_q;
        else if (ovf_q) result_o = 32'd0;
        else            result_o = r_s;
      end
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: forwarding, ALU, RV32M unit
// and the E->M pipeline register.
module execute_stage
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ValidE,
  input  logic                  FlushE,
  input  logic                  RegWriteE,
  input  logic                  ResultSrcE,
  input  logic                  MemWriteE,
  input  logic                  MemTypeE,
  input  logic [3:0]            ALUControlE,
  input  logic                  ALUSrcE,
  input  logic                  MulDivE,
  input  logic [2:0]            MulDivOpE,
  input  logic [XLEN-1:0]       RD1E,
  input  logic [XLEN-1:0]       RD2E,
  input  logic [XLEN-1:0]       ImmExtE,
  input  logic [REG_ADDR_W-1:0] RdE,
  input  logic [1:0]            ForwardAE,
  input  logic [1:0]            ForwardBE,
  input  logic [XLEN-1:0]       ResultW,
  output logic                  BusyE,
  output logic                  RegWriteM,
  output logic                  ResultSrcM,
  output logic                  MemWriteM,
  output logic                  MemTypeM,
  output logic [XLEN-1:0]       ALUResultM,
  output logic [XLEN-1:0]       WriteDataM,
  output logic [REG_ADDR_W-1:0] RdM
);

  logic [XLEN-1:0] src_a, fwd_b, src_b, alu_y;
  logic [XLEN-1:0] md_y;
  logic            md_done;

  logic                  rw_d, rs_d, mw_d, mt_d;
  logic [XLEN-1:0]       res_d, wd_d;
  logic [REG_ADDR_W-1:0] rd_d;

  // Forwarding muxes and ALU source select
  always_comb begin
    unique case (fwd_sel_e'(ForwardAE))
      FWD_W:   src_a = ResultW;
      FWD_M:   src_a = ALUResultM;
      default: src_a = RD1E;
    endcase
    unique case (fwd_sel_e'(ForwardBE))
      FWD_W:   fwd_b = ResultW;
      FWD_M:   fwd_b = ALUResultM;
      default: fwd_b = RD2E;
    endcase
    src_b = ALUSrcE ? ImmExtE : fwd_b;
  end

  // Single-cycle ALU
  always_comb begin
    alu_y = '0;
    unique case (alu_op_e'(ALUControlE))
      ALU_ADD:   alu_y = src_a + src_b;
      ALU_SUB:   alu_y = src_a - src_b;
      ALU_AND:   alu_y = src_a & src_b;
      ALU_OR:    alu_y = src_a | src_b;
      ALU_XOR:   alu_y = src_a ^ src_b;
      ALU_SLT:   alu_y = {31'd0,
                   $signed(src_a) < $signed(src_b)};
      ALU_SLTU:  alu_y = {31'd0, src_a < src_b};
      ALU_SLL:   alu_y = src_a << src_b[4:0];
      ALU_SRL:   alu_y = src_a >> src_b[4:0];
      ALU_SRA:   alu_y = $unsigned(
                   $signed(src_a) >>> src_b[4:0]);
      ALU_PASSB: alu_y = src_b;
      default:   alu_y = '0;
    endcase
  end

  muldiv_unit u_md (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (ValidE & MulDivE),
    .flush_i  (FlushE),
    .op_i     (MulDivOpE),
    .a_i      (src_a),
    .b_i      (fwd_b),
    .busy_o   (BusyE),
    .done_o   (md_done),
    .result_o (md_y)
  );

  // Next M contents: bubble unless a result is ready
  always_comb begin
    rw_d  = 1'b0;
    rs_d  = 1'b0;
    mw_d  = 1'b0;
    mt_d  = 1'b0;
    res_d = '0;
    wd_d  = '0;
    rd_d  = '0;
    if (!FlushE && ValidE && (!MulDivE || md_done)) begin
      rw_d  = RegWriteE;
      rs_d  = ResultSrcE;
      mw_d  = MemWriteE;
      mt_d  = MemTypeE;
      res_d = MulDivE ? md_y : alu_y;
      wd_d  = fwd_b;
      rd_d  = RdE;
    end
  end

  // E->M pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWriteM  <= 1'b0;
      ResultSrcM <= 1'b0;
      MemWriteM  <= 1'b0;
      MemTypeM   <= 1'b0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      RdM        <= '0;
    end else begin
      RegWriteM  <= rw_d;
      ResultSrcM <= rs_d;
      MemWriteM  <= mw_d;
      MemTypeM   <= mt_d;
      ALUResultM <= res_d;
      WriteDataM <= wd_d;
      RdM        <= rd_d;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage:
// ALU, forwarding, RV32M, flush and reset.
module tb_execute_stage;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidE, FlushE;
  logic        RegWriteE, ResultSrcE;
  logic        MemWriteE, MemTypeE;
  logic [3:0]  ALUControlE;
  logic        ALUSrcE, MulDivE;
  logic [2:0]  MulDivOpE;
  logic [31:0] RD1E, RD2E, ImmExtE, ResultW;
  logic [4:0]  RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        BusyE, RegWriteM, ResultSrcM;
  logic        MemWriteM, MemTypeM;
  logic [31:0] ALUResultM, WriteDataM;
  logic [4:0]  RdM;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n),
    .ValidE(ValidE), .FlushE(FlushE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE),
    .MemWriteE(MemWriteE), .MemTypeE(MemTypeE),
    .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
    .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE),
    .RdE(RdE), .ForwardAE(ForwardAE),
    .ForwardBE(ForwardBE), .ResultW(ResultW),
    .BusyE(BusyE), .RegWriteM(RegWriteM),
    .ResultSrcM(ResultSrcM), .MemWriteM(MemWriteM),
    .MemTypeM(MemTypeM), .ALUResultM(ALUResultM),
    .WriteDataM(WriteDataM), .RdM(RdM)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_e();
    ValidE = 0; FlushE = 0; RegWriteE = 0;
    ResultSrcE = 0; MemWriteE = 0; MemTypeE = 0;
    ALUControlE = 0; ALUSrcE = 0; MulDivE = 0;
    MulDivOpE = 0; RD1E = 0; RD2E = 0; ImmExtE = 0;
    RdE = 0; ForwardAE = 0; ForwardBE = 0;
    ResultW = 0;
  endtask

  task automatic alu_e(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] imm,
                       input logic src,
                       input logic [4:0] rd);
    idle_e();
    ValidE = 1; RegWriteE = 1;
    ALUControlE = op; RD1E = a; RD2E = b;
    ImmExtE = imm; ALUSrcE = src; RdE = rd;
  endtask

  task automatic md_e(input logic [2:0] op,
                      input logic [31:0] a,
                      input logic [31:0] b);
    idle_e();
    ValidE = 1; RegWriteE = 1; MulDivE = 1;
    MulDivOpE = op; RD1E = a; RD2E = b; RdE = 5'd9;
  endtask

  task automatic md_run(input string tag,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp);
    int n;
    int bad;
    md_e(op, a, b);
    n = 0;
    bad = 0;
    @(negedge clk);
    while (BusyE && n < 100) begin
      if (n > 0 && (RegWriteM || RdM != 0)) bad++;
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy"}, n, 33);
    chk({tag, "_bubble"}, bad, 0);
    step();
    chk(tag, ALUResultM, exp);
    chk({tag, "_rd"}, {27'd0, RdM}, 32'd9);
  endtask

  initial begin
    idle_e();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", ALUResultM, 0);
    chk("rst_rd", {27'd0, RdM}, 0);
    chk("rst_busy", {31'd0, BusyE}, 0);
    rst_n = 1;
    step();

    // ADD with immediate
    alu_e(ALU_ADD, 5, 0, 7, 1, 5'd3);
    step();
    chk("add", ALUResultM, 12);
    chk("add_rw", {31'd0, RegWriteM}, 1);
    chk("add_rd", {27'd0, RdM}, 3);

    // SUB with A forwarded from M
    alu_e(ALU_ADD, 32'h10, 0, 0, 1, 5'd4);
    step();
    alu_e(ALU_SUB, 32'h999, 1, 0, 0, 5'd5);
    ForwardAE = 2'b10;
    step();
    chk("sub_fwdm", ALUResultM, 32'hF);

    // Store with B forwarded from W
    alu_e(ALU_ADD, 32'h100, 32'h55, 8, 1, 5'd0);
    RegWriteE = 0; MemWriteE = 1;
    ForwardBE = 2'b01; ResultW = 32'hABCD1234;
    step();
    chk("st_addr", ALUResultM, 32'h108);
    chk("st_data", WriteDataM, 32'hABCD1234);
    chk("st_mw", {31'd0, MemWriteM}, 1);

    // Misc ALU ops; ForwardAE=11 selects RD1E
    alu_e(ALU_SRA, 32'h8000_0000, 4, 0, 0, 5'd6);
    ForwardAE = 2'b11;
    step();
    chk("sra", ALUResultM, 32'hF800_0000);
    alu_e(ALU_SLT, 32'hFFFF_FFFF, 1, 0, 0, 5'd6);
    step();
    chk("slt", ALUResultM, 1);
    alu_e(ALU_SLTU, 32'hFFFF_FFFF, 1, 0, 0, 5'd6);
    step();
    chk("sltu", ALUResultM, 0);
    alu_e(ALU_SLL, 32'h3, 32'h21, 0, 0, 5'd6);
    step();
    chk("sll", ALUResultM, 32'h6);
    alu_e(ALU_XOR, 32'hF0F0, 32'h0FF0, 0, 0, 5'd6);
    step();
    chk("xor", ALUResultM, 32'hFF00);

    // Invalid instruction -> bubble
    alu_e(ALU_ADD, 1, 1, 0, 0, 5'd7);
    ValidE = 0;
    step();
    chk("bub_rw", {31'd0, RegWriteM}, 0);
    chk("bub_rd", {27'd0, RdM}, 0);

    // Multiply / divide
    md_run("mulhu", MD_MULHU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFE);
    md_run("mul", MD_MUL, 32'hFFFF_FFF9, 3,
           32'hFFFF_FFEB);
    md_run("mulh", MD_MULH, 32'hFFFF_FFF9, 3,
           32'hFFFF_FFFF);
    md_run("mulhsu", MD_MULHSU, 32'hFFFF_FFFF,
           32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_run("div", MD_DIV, 7, 32'hFFFF_FFFE,
           32'hFFFF_FFFD);
    md_run("rem", MD_REM, 7, 32'hFFFF_FFFE, 1);
    md_run("rem_neg", MD_REM, 32'hFFFF_FFF9, 2,
           32'hFFFF_FFFF);
    md_run("divu0", MD_DIVU, 5, 0, 32'hFFFF_FFFF);
    md_run("remu0", MD_REMU, 5, 0, 5);
    md_run("div_ovf", MD_DIV, 32'h8000_0000,
           32'hFFFF_FFFF, 32'h8000_0000);
    md_run("rem_ovf", MD_REM, 32'h8000_0000,
           32'hFFFF_FFFF, 0);

    // MUL then dependent ADD forwarded from M
    md_run("mul_dep", MD_MUL, 6, 7, 42);
    alu_e(ALU_ADD, 0, 0, 1, 1, 5'd10);
    ForwardAE = 2'b10;
    step();
    chk("add_dep", ALUResultM, 43);

    // Flush in RUN cycle 10
    md_e(MD_DIV, 100, 3);
    repeat (10) step();
    chk("fl_busy_pre", {31'd0, BusyE}, 1);
    FlushE = 1;
    #1;
    chk("fl_busy", {31'd0, BusyE}, 0);
    step();
    chk("fl_rw", {31'd0, RegWriteM}, 0);
    chk("fl_rd", {27'd0, RdM}, 0);
    FlushE = 0;
    ValidE = 0;
    #1;
    chk("fl_idle", {31'd0, BusyE}, 0);
    md_run("after_fl", MD_DIVU, 100, 3, 33);

    // Async reset clears a loaded M at once
    alu_e(ALU_ADD, 32'h1234, 0, 1, 1, 5'd12);
    step();
    chk("pre_rst", ALUResultM, 32'h1235);
    #2;
    rst_n = 0;
    #1;
    chk("arst_res", ALUResultM, 0);
    chk("arst_rw", {31'd0, RegWriteM}, 0);
    chk("arst_rd", {27'd0, RdM}, 0);
    rst_n = 1;

    // Async reset during RUN
    md_e(MD_MUL, 3, 4);
    repeat (3) step();
    chk("run_busy", {31'd0, BusyE}, 1);
    #2;
    rst_n = 0;
    #1;
    chk("rrst_busy", {31'd0, BusyE}, 0);
    chk("rrst_res", ALUResultM, 0);
    idle_e();
    step();
    rst_n = 1;
    step();
    chk("post_rst", {31'd0, BusyE}, 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
